logic_pod_ram_writer: RTL and testbench

- DRAM-side consumer of one logic pod's capture stream.
- Reads the pod's address FIFO (burst base addresses) and data FIFO (128-bit compressed sample words).
- Issues each burst to the DDR controller's native app write interface (command port plus write-data port).
- One instance per pod, in the top-level DDR arbiter domain; the arbiter muxes app ports among writers.

---
 rtl/logic_pod_ram_writer.sv | 158 +++++++++++++++
 tb/tb_logic_pod_ram_writer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_pod_ram_writer.sv
// logic_pod_ram_writer
//   Drains one logic pod's capture FIFOs into the DDR controller app write
//   interface. Each address FIFO entry is a burst base; BURST_WORDS 128-bit
//   words from the data FIFO are written at base + k*ADDR_STEP.
//
// Ports
//   clk_ram_2x, rst_n             clock, async active-low reset
//   ram_ready                     DRAM calibrated, gates burst start only
//   ram_addr_rd_en/_data/_size    address FIFO pop / data (1 cycle latency) / occupancy
//   ram_data_rd_en/_data/_size    data FIFO pop / data (1 cycle latency) / occupancy
//   app_en/_cmd/_addr/app_rdy     controller command port (write only)
//   app_wdf_wren/_data/_end/_rdy  controller write-data port
//   busy                          burst in progress (address pop .. last accept)
//   bursts_done                   completed burst count, wraps
module logic_pod_ram_writer #(
   parameter int unsigned BURST_WORDS = 16,
   parameter int unsigned ADDR_STEP   = 8,
   parameter int unsigned ADDR_WIDTH  = 29
) (
   input  logic                  clk_ram_2x,
   input  logic                  rst_n,
   input  logic                  ram_ready,
   output logic                  ram_addr_rd_en,
   input  logic [ADDR_WIDTH-1:0] ram_addr_rd_data,
   input  logic [7:0]            ram_addr_rd_size,
   output logic                  ram_data_rd_en,
   input  logic [127:0]          ram_data_rd_data,
   input  logic [9:0]            ram_data_rd_size,
   output logic                  app_en,
   output logic [2:0]            app_cmd,
   output logic [ADDR_WIDTH-1:0] app_addr,
   input  logic                  app_rdy,
   output logic                  app_wdf_wren,
   output logic [127:0]          app_wdf_data,
   output logic                  app_wdf_end,
   input  logic                  app_wdf_rdy,
   output logic                  busy,
   output logic [31:0]           bursts_done
);

   localparam logic [7:0] BW = 8'(BURST_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_LATCH, S_RUN} state_t;

   state_t                r_state;
   logic                  r_addr_rd_en;
   logic                  r_app_en;
   logic [ADDR_WIDTH-1:0] r_app_addr;
   logic [7:0]            r_cmd_left;
   logic [7:0]            r_data_left;
   logic [7:0]            r_fetched;
   logic                  r_inflight;
   logic [127:0]          r_buf [2];
   logic                  r_head;
   logic [1:0]            r_occ;
   logic                  r_busy;
   logic [31:0]           r_bursts_done;

   logic       w_cmd_acc;
   logic       w_wdf_wren;
   logic       w_wdf_acc;
   logic [1:0] w_occ_after_pop;
   logic       w_data_rd_en;
   logic       w_tail;
   logic       w_cmd_last;
   logic       w_data_last;

   always_comb begin
      w_cmd_acc       = r_app_en & app_rdy;
      w_wdf_wren      = (r_occ != 2'd0);
      w_wdf_acc       = w_wdf_wren & app_wdf_rdy;
      w_occ_after_pop = r_occ - {1'b0, w_wdf_acc};
      // Occupancy after this cycle's pop plus the word still in flight from
      // the FIFO must leave room, so the buffer can never overflow.
      w_data_rd_en    = (r_state == S_RUN) && (r_fetched < BW) &&
                        ((w_occ_after_pop + {1'b0, r_inflight}) < 2'd2);
      // A push only ever happens with occupancy <= 1, so the free slot is
      // head when empty and the other slot when one entry is held.
      w_tail          = r_head ^ r_occ[0];
      w_cmd_last      = (r_cmd_left == 8'd0) || ((r_cmd_left == 8'd1) && w_cmd_acc);
      w_data_last     = (r_data_left == 8'd0) || ((r_data_left == 8'd1) && w_wdf_acc);
   end

   always_ff @(posedge clk_ram_2x or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_addr_rd_en  <= 1'b0;
         r_app_en      <= 1'b0;
         r_app_addr    <= '0;
         r_cmd_left    <= '0;
         r_data_left   <= '0;
         r_fetched     <= '0;
         r_inflight    <= 1'b0;
         for (int unsigned i = 0; i < 2; i++) r_buf[i] <= '0;
         r_head        <= 1'b0;
         r_occ         <= '0;
         r_busy        <= 1'b0;
         r_bursts_done <= '0;
      end else begin
         r_inflight <= w_data_rd_en;
         if (w_data_rd_en) r_fetched <= r_fetched + 8'd1;
         if (r_inflight) r_buf[w_tail] <= ram_data_rd_data;
         if (w_wdf_acc) r_head <= ~r_head;
         r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_wdf_acc};

         case (r_state)
            S_IDLE: begin
               if (ram_ready && (ram_addr_rd_size != 8'd0) &&
                   (ram_data_rd_size >= 10'(BURST_WORDS))) begin
                  r_addr_rd_en <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= S_LATCH;
               end
            end
            // LATCH spans two cycles: the pop cycle, then the cycle in which
            // the FIFO presents the popped base address.
            S_LATCH: begin
               if (r_addr_rd_en) begin
                  r_addr_rd_en <= 1'b0;
               end else begin
                  r_app_addr  <= ram_addr_rd_data;
                  r_app_en    <= 1'b1;
                  r_cmd_left  <= BW;
                  r_data_left <= BW;
                  r_fetched   <= '0;
                  r_state     <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_cmd_acc) begin
                  r_cmd_left <= r_cmd_left - 8'd1;
                  r_app_addr <= r_app_addr + ADDR_WIDTH'(ADDR_STEP);
                  if (r_cmd_left == 8'd1) r_app_en <= 1'b0;
               end
               if (w_wdf_acc) r_data_left <= r_data_left - 8'd1;
               if (w_cmd_last && w_data_last) begin
                  r_busy        <= 1'b0;
                  r_bursts_done <= r_bursts_done + 32'd1;
                  r_state       <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ram_addr_rd_en = r_addr_rd_en;
   assign ram_data_rd_en = w_data_rd_en;
   assign app_en         = r_app_en;
   assign app_cmd        = 3'b000;
   assign app_addr       = r_app_addr;
   assign app_wdf_wren   = w_wdf_wren;
   assign app_wdf_data   = r_buf[r_head];
   assign app_wdf_end    = w_wdf_wren;
   assign busy           = r_busy;
   assign bursts_done    = r_bursts_done;

endmodule

// File: tb/tb_logic_pod_ram_writer.sv
// Directed bench for logic_pod_ram_writer: models both capture FIFOs with
// one-cycle read latency, logs every accepted command/data beat and compares
// against hand-derived address and data sequences.
module tb_logic_pod_ram_writer;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ram_ready = 1'b0;
   logic          ram_addr_rd_en;
   logic [28:0]   ram_addr_rd_data = '0;
   logic [7:0]    ram_addr_rd_size;
   logic          ram_data_rd_en;
   logic [127:0]  ram_data_rd_data = '0;
   logic [9:0]    ram_data_rd_size;
   logic          app_en;
   logic [2:0]    app_cmd;
   logic [28:0]   app_addr;
   logic          app_rdy = 1'b1;
   logic          app_wdf_wren;
   logic [127:0]  app_wdf_data;
   logic          app_wdf_end;
   logic          app_wdf_rdy = 1'b1;
   logic          busy;
   logic [31:0]   bursts_done;

   always #5 clk = ~clk;

   logic_pod_ram_writer #(.BURST_WORDS(16), .ADDR_STEP(8), .ADDR_WIDTH(29)) dut (
      .clk_ram_2x(clk), .rst_n(rst_n), .ram_ready(ram_ready),
      .ram_addr_rd_en(ram_addr_rd_en), .ram_addr_rd_data(ram_addr_rd_data),
      .ram_addr_rd_size(ram_addr_rd_size),
      .ram_data_rd_en(ram_data_rd_en), .ram_data_rd_data(ram_data_rd_data),
      .ram_data_rd_size(ram_data_rd_size),
      .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
      .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
      .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
      .busy(busy), .bursts_done(bursts_done)
   );

   // FIFO model: initial block writes entries, the always block pops them.
   logic [28:0]  addr_mem [32];
   logic [127:0] data_mem [256];
   int a_wr = 0, d_wr = 0, a_rd = 0, d_rd = 0;
   int a_under = 0, d_under = 0;
   logic flush = 1'b0;

   assign ram_addr_rd_size = 8'(a_wr - a_rd);
   assign ram_data_rd_size = 10'(d_wr - d_rd);

   always @(posedge clk) begin
      if (flush) begin
         a_rd <= a_wr;
         d_rd <= d_wr;
      end else begin
         if (ram_addr_rd_en) begin
            if (a_rd < a_wr) begin
               ram_addr_rd_data <= addr_mem[a_rd];
               a_rd <= a_rd + 1;
            end else a_under <= a_under + 1;
         end
         if (ram_data_rd_en) begin
            if (d_rd < d_wr) begin
               ram_data_rd_data <= data_mem[d_rd];
               d_rd <= d_rd + 1;
            end else d_under <= d_under + 1;
         end
      end
   end

   // Accept monitor.
   logic [28:0]  cmd_log [64];
   logic [127:0] dat_log [64];
   int cmd_n = 0, d_acc = 0, a_pops = 0, d_pops = 0;
   logic log_clr = 1'b0;

   always @(posedge clk) begin
      if (log_clr) begin
         cmd_n <= 0; d_acc <= 0; a_pops <= 0; d_pops <= 0;
      end else begin
         if (app_en && app_rdy) begin
            cmd_log[cmd_n] <= app_addr;
            cmd_n <= cmd_n + 1;
         end
         if (app_wdf_wren && app_wdf_rdy) begin
            dat_log[d_acc] <= app_wdf_data;
            d_acc <= d_acc + 1;
         end
         if (ram_addr_rd_en) a_pops <= a_pops + 1;
         if (ram_data_rd_en) d_pops <= d_pops + 1;
      end
   end

   int n_checks = 0;
   int n_pass = 0;

   function automatic logic [127:0] mkword(input int b, input int i);
      return {32'(b), 32'(i), 32'hDEADBEEF ^ 32'(b * 64 + i), 32'h5A5A0000 | 32'(i)};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One clock; verifies hold-while-not-ready and the outstanding-word bound.
   task automatic step();
      logic         p_valid, p_en, p_rdy, p_wren, p_wrdy;
      logic [28:0]  p_addr;
      logic [127:0] p_data;
      p_valid = rst_n; p_en = app_en; p_rdy = app_rdy; p_addr = app_addr;
      p_wren = app_wdf_wren; p_wrdy = app_wdf_rdy; p_data = app_wdf_data;
      @(negedge clk);
      if (p_valid && rst_n) begin
         if (p_en && !p_rdy) begin
            check("cmd_hold_en", app_en, 1'b1);
            check("cmd_hold_addr", app_addr, p_addr);
         end
         if (p_wren && !p_wrdy) begin
            check("wdf_hold_wren", app_wdf_wren, 1'b1);
            check("wdf_hold_data", app_wdf_data, p_data);
         end
         if (app_en || app_wdf_wren) begin
            check("outstanding_le2", (d_pops - d_acc) <= 2, 1'b1);
            check("app_cmd_write", app_cmd, 3'b000);
            check("wdf_end_eq_wren", app_wdf_end, app_wdf_wren);
         end
      end
   endtask

   task automatic clear_logs();
      log_clr = 1'b1;
      @(negedge clk);
      log_clr = 1'b0;
   endtask

   task automatic push_addr(input logic [28:0] a);
      addr_mem[a_wr] = a;
      a_wr++;
   endtask

   task automatic push_words(input int b, input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         data_mem[d_wr] = mkword(b, i);
         d_wr++;
      end
   endtask

   task automatic run_until_done(input string tag, input logic [31:0] target);
      for (int c = 0; c < 600 && bursts_done != target; c++) step();
      check({tag, "_done_in_time"}, bursts_done, target);
   endtask

   task automatic check_burst(input string tag, input int off,
                              input logic [28:0] base, input int b);
      logic [28:0] ea;
      for (int i = 0; i < 16; i++) begin
         ea = 29'(base + 29'(8 * i));
         check({tag, "_addr"}, cmd_log[off + i], ea);
         check({tag, "_data"}, dat_log[off + i], mkword(b, i));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr_rd_en"}, ram_addr_rd_en, 1'b0);
      check({tag, "_data_rd_en"}, ram_data_rd_en, 1'b0);
      check({tag, "_app_en"}, app_en, 1'b0);
      check({tag, "_app_cmd"}, app_cmd, 3'b000);
      check({tag, "_app_addr"}, app_addr, 29'd0);
      check({tag, "_wdf_wren"}, app_wdf_wren, 1'b0);
      check({tag, "_wdf_data"}, app_wdf_data, 128'd0);
      check({tag, "_wdf_end"}, app_wdf_end, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_bursts_done"}, bursts_done, 32'd0);
   endtask

   initial begin
      logic seen;
      logic pb;
      logic expect_pop;
      int   falls;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      ram_ready = 1'b1;
      step();

      // 1: free-flowing burst
      clear_logs();
      push_addr(29'h0000100);
      push_words(1, 0, 16);
      run_until_done("t1", 32'd1);
      check("t1_cmd_count", cmd_n, 16);
      check("t1_data_count", d_acc, 16);
      check_burst("t1", 0, 29'h0000100, 1);
      check("t1_busy_low", busy, 1'b0);
      check("t1_addr_pops", a_pops, 1);
      check("t1_data_pops", d_pops, 16);

      // 2: back-pressure on both ports
      clear_logs();
      push_addr(29'h0000200);
      push_words(2, 0, 16);
      for (int c = 0; c < 600 && bursts_done != 32'd2; c++) begin
         app_rdy = c[0];
         app_wdf_rdy = (c >= 20);
         if (c == 19) check("t2_stalled_pops", d_pops, 2);
         step();
      end
      app_rdy = 1'b1;
      app_wdf_rdy = 1'b1;
      check("t2_done_in_time", bursts_done, 32'd2);
      check("t2_cmd_count", cmd_n, 16);
      check("t2_data_count", d_acc, 16);
      check_burst("t2", 0, 29'h0000200, 2);

      // 3: address wrap at 2^29
      clear_logs();
      push_addr(29'h1FFFFFF8);
      push_words(3, 0, 16);
      run_until_done("t3", 32'd3);
      check("t3_second_addr_wrap", cmd_log[1], 29'h0000000);
      check_burst("t3", 0, 29'h1FFFFFF8, 3);

      // 4: ram_ready gating
      clear_logs();
      ram_ready = 1'b0;
      push_addr(29'h0000400);
      push_words(4, 0, 16);
      seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
         step();
         seen = seen | ram_addr_rd_en | ram_data_rd_en | busy;
      end
      check("t4_no_start_while_not_ready", seen, 1'b0);
      ram_ready = 1'b1;
      for (int c = 0; c < 100 && cmd_n < 3; c++) step();
      check("t4_three_cmds", cmd_n >= 3, 1'b1);
      ram_ready = 1'b0;
      step();
      check("t4_busy_after_drop", busy, 1'b1);
      run_until_done("t4", 32'd4);
      check("t4_cmd_count", cmd_n, 16);
      check("t4_data_count", d_acc, 16);
      check_burst("t4", 0, 29'h0000400, 4);

      // 5: data threshold, then three queued bursts
      clear_logs();
      ram_ready = 1'b1;
      push_addr(29'h0000800);
      push_words(5, 0, 15);
      for (int c = 0; c < 30; c++) step();
      check("t5_no_addr_pop_at_15", a_pops, 0);
      check("t5_no_data_pop_at_15", d_pops, 0);
      check("t5_busy_at_15", busy, 1'b0);
      push_words(5, 15, 1);
      push_addr(29'h0000900);
      push_words(6, 0, 16);
      push_addr(29'h0000A00);
      push_words(7, 0, 16);
      falls = 0;
      expect_pop = 1'b0;
      pb = busy;
      for (int c = 0; c < 900 && bursts_done != 32'd7; c++) begin
         step();
         if (expect_pop) begin
            check("t5_pop_cycle_after_idle", ram_addr_rd_en, 1'b1);
            expect_pop = 1'b0;
         end
         if (pb && !busy && bursts_done != 32'd7) begin
            expect_pop = 1'b1;
            falls++;
         end
         pb = busy;
      end
      check("t5_done_in_time", bursts_done, 32'd7);
      check("t5_intermediate_ends", falls, 2);
      check("t5_addr_pops", a_pops, 3);
      check("t5_data_pops", d_pops, 48);
      check_burst("t5_b0", 0, 29'h0000800, 5);
      check_burst("t5_b1", 16, 29'h0000900, 6);
      check_burst("t5_b2", 32, 29'h0000A00, 7);

      // 6: reset mid-burst
      clear_logs();
      push_addr(29'h0000B00);
      push_words(8, 0, 16);
      for (int c = 0; c < 100 && d_acc < 5; c++) step();
      check("t6_five_beats", d_acc, 5);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t6_reset");
      flush = 1'b1;
      log_clr = 1'b1;
      repeat (2) @(negedge clk);
      flush = 1'b0;
      log_clr = 1'b0;
      push_addr(29'h0000C00);
      push_words(9, 0, 16);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) step();
      check("t6_busy_new_burst", busy, 1'b1);
      check("t6_count_zero_before_done", bursts_done, 32'd0);
      run_until_done("t6", 32'd1);
      check("t6_cmd_count", cmd_n, 16);
      check("t6_data_count", d_acc, 16);
      check_burst("t6", 0, 29'h0000C00, 9);
      check("t6_addr_pops", a_pops, 1);

      check("addr_fifo_underflow", a_under, 0);
      check("data_fifo_underflow", d_under, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
